// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction arbiter: field widths and FSM state encoding.
package i2c_pkg;

    localparam int I2C_CNT_W     = 2;
    localparam int I2C_DEV_W     = 7;
    localparam int I2C_MAX_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        READBACK,
        RESP
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin picker: selects the first requester at or after last+1 (mod N).
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   last,
    output logic [2:0]   gnt_id,
    output logic         any
);

    int best;

    // Each requester's distance from the slot after the last owner; the smallest distance wins.
    always_comb begin
        gnt_id = '0;
        any    = 1'b0;
        best   = N;
        for (int j = 0; j < N; j++) begin
            if (req[j] && (((j - int'(last) - 1 + 2 * N) % N) < best)) begin
                best   = (j - int'(last) - 1 + 2 * N) % N;
                gnt_id = 3'(j);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one I2C controller among N requesters: round-robin grant, launch, completion tracking,
// optional read-back of up to four bytes, and a one-cycle response to the owning requester.
module i2c_txn_arbiter
    import i2c_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               req_valid,
    input  logic [N-1:0]               req_rd,
    input  logic [I2C_CNT_W*N-1:0]     req_cnt,
    input  logic [8*N-1:0]             req_data,
    input  logic [I2C_DEV_W*N-1:0]     req_dev,
    output logic [N-1:0]               rsp_valid,
    output logic                       rsp_fail,
    output logic [8*I2C_MAX_BYTES-1:0] rsp_data,
    output logic [2:0]                 grant_id,
    output logic                       arb_busy,
    output logic                       tx_en,
    output logic                       tx_rd,
    output logic [I2C_CNT_W-1:0]       tx_cnt,
    output logic [7:0]                 tx_data,
    output logic [I2C_DEV_W-1:0]       dev_id,
    input  logic                       busy,
    input  logic                       tx_fail,
    output logic [1:0]                 rd_addr,
    input  logic [7:0]                 rd_data
);

    arb_state_t           state;
    logic [2:0]           last_grant;
    logic [2:0]           pick;
    logic                 pick_any;
    logic [7:0]           timer;
    logic                 phase;
    logic [N-1:0]         owner;
    logic                 sel_rd;
    logic [I2C_CNT_W-1:0] sel_cnt;
    logic [7:0]           sel_data;
    logic [I2C_DEV_W-1:0] sel_dev;

    rr_arbiter #(.N(N)) u_rr (
        .req    (req_valid),
        .last   (last_grant),
        .gnt_id (pick),
        .any    (pick_any)
    );

    assign owner = {{(N-1){1'b0}}, 1'b1} << grant_id;

    always_comb begin
        sel_rd   = 1'b0;
        sel_cnt  = '0;
        sel_data = '0;
        sel_dev  = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(pick) == i) begin
                sel_rd   = req_rd[i];
                sel_cnt  = req_cnt[I2C_CNT_W*i +: I2C_CNT_W];
                sel_data = req_data[8*i +: 8];
                sel_dev  = req_dev[I2C_DEV_W*i +: I2C_DEV_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 3'(N - 1);
            grant_id   <= '0;
            arb_busy   <= 1'b0;
            tx_en      <= 1'b0;
            tx_rd      <= 1'b0;
            tx_cnt     <= '0;
            tx_data    <= '0;
            dev_id     <= '0;
            rsp_valid  <= '0;
            rsp_fail   <= 1'b0;
            rsp_data   <= '0;
            rd_addr    <= '0;
            timer      <= '0;
            phase      <= 1'b0;
        end else begin
            tx_en     <= 1'b0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (pick_any && !busy) begin
                        grant_id <= pick;
                        tx_rd    <= sel_rd;
                        tx_cnt   <= sel_cnt;
                        tx_data  <= sel_data;
                        dev_id   <= sel_dev;
                        arb_busy <= 1'b1;
                        rsp_fail <= 1'b0;
                        tx_en    <= 1'b1;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    timer <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // The cycle that would bring the timer to TIMEOUT ends the wait.
                    if (busy) begin
                        state <= WAIT_DONE;
                    end else if (({1'b0, timer} + 9'd1) == 9'(TIMEOUT)) begin
                        rsp_fail  <= 1'b1;
                        rsp_valid <= owner;
                        state     <= RESP;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!busy) begin
                        rsp_fail <= tx_fail;
                        if (tx_rd && !tx_fail) begin
                            rd_addr <= '0;
                            phase   <= 1'b0;
                            state   <= READBACK;
                        end else begin
                            rsp_valid <= owner;
                            state     <= RESP;
                        end
                    end
                end
                READBACK: begin
                    // Each address is held two cycles; the buffer is sampled on the second.
                    if (!phase) begin
                        phase <= 1'b1;
                    end else begin
                        rsp_data[8*rd_addr +: 8] <= rd_data;
                        phase <= 1'b0;
                        if (rd_addr == tx_cnt) begin
                            rd_addr   <= '0;
                            rsp_valid <= owner;
                            state     <= RESP;
                        end else begin
                            rd_addr <= rd_addr + 2'd1;
                        end
                    end
                end
                RESP: begin
                    last_grant <= grant_id;
                    rsp_data   <= '0;
                    rsp_fail   <= 1'b0;
                    arb_busy   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Bench for i2c_txn_arbiter: controller model on the command port, table of transactions,
// contention and mid-transaction reset sequences, scoreboard of expected responses.
module tb_i2c_txn_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_rd = '0;
    logic [2*N-1:0] req_cnt = '0;
    logic [8*N-1:0] req_data = '0;
    logic [7*N-1:0] req_dev = '0;
    logic [N-1:0]   rsp_valid;
    logic           rsp_fail;
    logic [31:0]    rsp_data;
    logic [2:0]     grant_id;
    logic           arb_busy;
    logic           tx_en;
    logic           tx_rd;
    logic [1:0]     tx_cnt;
    logic [7:0]     tx_data;
    logic [6:0]     dev_id;
    logic           busy = 1'b0;
    logic           tx_fail = 1'b0;
    logic [1:0]     rd_addr;
    logic [7:0]     rd_data;
    logic [31:0]    ctrl_buf = '0;

    i2c_txn_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_cnt   (req_cnt),
        .req_data  (req_data),
        .req_dev   (req_dev),
        .rsp_valid (rsp_valid),
        .rsp_fail  (rsp_fail),
        .rsp_data  (rsp_data),
        .grant_id  (grant_id),
        .arb_busy  (arb_busy),
        .tx_en     (tx_en),
        .tx_rd     (tx_rd),
        .tx_cnt    (tx_cnt),
        .tx_data   (tx_data),
        .dev_id    (dev_id),
        .busy      (busy),
        .tx_fail   (tx_fail),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    // Controller read-back buffer as seen by the arbiter.
    assign rd_data = ctrl_buf[8*rd_addr +: 8];

    typedef struct packed {
        logic [2:0]  id;
        logic        rd;
        logic [1:0]  cnt;
        logic [6:0]  dev;
        logic [7:0]  data;
        logic        fail;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        int          id;
        logic        rd;
        logic [1:0]  cnt;
        logic [6:0]  dev;
        logic [7:0]  data;
        logic [31:0] buf_v;
        logic        fail;
        logic [31:0] rdata;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[14];

    int   errors = 0;
    int   checks = 0;
    int   ncyc = 0;
    int   ten_cyc = -1;
    int   fall_cyc = -1;
    int   m_state = 0;
    int   m_cnt = 0;
    logic m_nack = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    // Bytes 0..cnt of the controller buffer, higher bytes zero.
    function automatic logic [31:0] read_model(input logic [31:0] b, input logic [1:0] cnt);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 4; k++)
            if (k <= int'(cnt)) r[8*k +: 8] = b[8*k +: 8];
        return r;
    endfunction

    task automatic issue(input int id, input logic rd, input logic [1:0] cnt, input logic [6:0] dev,
                         input logic [7:0] data, input logic fail, input logic [31:0] rdata);
        exp_t e;
        req_rd[id]          = rd;
        req_cnt[2*id +: 2]  = cnt;
        req_data[8*id +: 8] = data;
        req_dev[7*id +: 7]  = dev;
        req_valid[id]       = 1'b1;
        e.id    = 3'(id);
        e.rd    = rd;
        e.cnt   = cnt;
        e.dev   = dev;
        e.data  = data;
        e.fail  = fail;
        e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("wait_budget", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            req_valid = '0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {tx_en, rsp_valid, rsp_fail, rsp_data, arb_busy, grant_id,
                     tx_rd, tx_cnt, tx_data, dev_id, rd_addr}, 64'd0);
    endtask

    // Controller model and scoreboard, all sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            ncyc++;
            if (rst) begin
                busy     = 1'b0;
                tx_fail  = 1'b0;
                m_state  = 0;
                ten_cyc  = -1;
                fall_cyc = -1;
                if (rsp_valid != '0) check("rsp_in_reset", 64'(rsp_valid), 64'd0);
            end else begin
                if (rsp_valid != '0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp", 64'(rsp_valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_owner", 64'(rsp_valid), 64'd1 << e.id);
                        check("rsp_fail", 64'(rsp_fail), 64'(e.fail));
                        check("rsp_data", 64'(rsp_data), 64'(e.rdata));
                        if (e.dev == 7'h00)
                            check("timeout_latency", 64'(ncyc - ten_cyc), 64'(TIMEOUT + 1));
                        else
                            check("rsp_latency", 64'(ncyc - fall_cyc),
                                  64'(1 + ((e.rd && !e.fail) ? 2 * (int'(e.cnt) + 1) : 0)));
                    end
                    req_valid = req_valid & ~rsp_valid;
                    if (m_state == 3) m_state = 0;
                    fall_cyc = -1;
                end else if (fall_cyc >= 0 && exp_q.size() > 0 && exp_q[0].rd && !exp_q[0].fail &&
                             ncyc > fall_cyc && ncyc <= fall_cyc + 2 * (int'(exp_q[0].cnt) + 1)) begin
                    check("rd_addr_step", 64'(rd_addr), 64'((ncyc - fall_cyc - 1) / 2));
                end

                if (m_state != 0) check("tx_en_overlap", 64'(tx_en), 64'd0);
                case (m_state)
                    0: if (tx_en) begin
                        check("busy_at_tx_en", 64'(busy), 64'd0);
                        if (exp_q.size() > 0)
                            check("tx_fields", {tx_rd, tx_cnt, tx_data, dev_id},
                                  {exp_q[0].rd, exp_q[0].cnt, exp_q[0].data, exp_q[0].dev});
                        else
                            check("unexpected_tx_en", 64'(tx_en), 64'd0);
                        ten_cyc  = ncyc;
                        fall_cyc = -1;
                        m_nack   = (dev_id == 7'h7F);
                        if (dev_id == 7'h00) begin
                            m_state = 3;
                        end else begin
                            m_cnt   = $urandom_range(1, 4);
                            m_state = 1;
                        end
                    end
                    1: begin
                        m_cnt--;
                        if (m_cnt == 0) begin
                            busy    = 1'b1;
                            tx_fail = 1'b0;
                            m_cnt   = 4;
                            m_state = 2;
                        end
                    end
                    2: begin
                        m_cnt--;
                        if (m_cnt == 0) begin
                            busy     = 1'b0;
                            tx_fail  = m_nack;
                            fall_cyc = ncyc;
                            m_state  = 0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    initial begin
        int n;
        int mode;

        // id, rd, cnt, dev, data, controller buffer, expected fail, expected rsp_data
        vecs[0]  = '{0, 1'b0, 2'd0, 7'h05, 8'h29, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[1]  = '{2, 1'b1, 2'd1, 7'h29, 8'h00, 32'hEEFF_07C4, 1'b0, 32'h0000_07C4};
        vecs[2]  = '{1, 1'b0, 2'd0, 7'h7F, 8'h10, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[3]  = '{3, 1'b1, 2'd2, 7'h7F, 8'h00, 32'h1234_5678, 1'b1, 32'h0000_0000};
        vecs[4]  = '{0, 1'b1, 2'd3, 7'h50, 8'h01, 32'h4433_2211, 1'b0, 32'h4433_2211};
        vecs[5]  = '{1, 1'b1, 2'd0, 7'h00, 8'h02, 32'h0000_0099, 1'b1, 32'h0000_0000};
        vecs[6]  = '{2, 1'b0, 2'd2, 7'h33, 8'hC3, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000};
        for (int i = 7; i < 13; i++) begin
            mode          = $urandom_range(0, 3);
            vecs[i].id    = $urandom_range(0, N - 1);
            vecs[i].rd    = 1'($urandom_range(0, 1));
            vecs[i].cnt   = 2'($urandom_range(0, 3));
            vecs[i].dev   = (mode == 0) ? 7'h7F : (mode == 1) ? 7'h00 : 7'($urandom_range(1, 126));
            vecs[i].data  = 8'($urandom_range(0, 255));
            vecs[i].buf_v = $urandom;
            vecs[i].fail  = (mode <= 1);
            vecs[i].rdata = (vecs[i].rd && mode > 1) ? read_model(vecs[i].buf_v, vecs[i].cnt) : 32'd0;
        end
        vecs[13] = '{3, 1'b1, 2'd0, 7'h10, 8'h00, 32'h5A5A_5AA5, 1'b0, 32'h0000_00A5};

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_outputs");
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("idle_after_reset");

        for (int i = 0; i < 14; i++) begin
            ctrl_buf = vecs[i].buf_v;
            @(posedge clk);
            #1;
            issue(vecs[i].id, vecs[i].rd, vecs[i].cnt, vecs[i].dev, vecs[i].data,
                  vecs[i].fail, vecs[i].rdata);
            wait_idle(300);
        end

        // Three requesters in one cycle after requester 3 was served: order 0, 1, 3.
        ctrl_buf = 32'h1122_BEEF;
        @(posedge clk);
        #1;
        issue(0, 1'b0, 2'd0, 7'h12, 8'hA1, 1'b0, 32'd0);
        issue(1, 1'b0, 2'd1, 7'h7F, 8'hB2, 1'b1, 32'd0);
        issue(3, 1'b1, 2'd1, 7'h22, 8'hC3, 1'b0, 32'h0000_BEEF);
        wait_idle(600);

        // Reset while the arbiter waits for busy to fall.
        @(posedge clk);
        #1;
        issue(1, 1'b0, 2'd0, 7'h40, 8'h5A, 1'b0, 32'd0);
        n = 0;
        while (m_state != 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reached_wait_done", 64'(m_state), 64'd2);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_reset_outputs");
        exp_q.delete();
        req_valid = '0;
        ctrl_buf  = 32'h0000_0077;
        issue(0, 1'b0, 2'd0, 7'h0A, 8'h3C, 1'b0, 32'd0);
        issue(2, 1'b1, 2'd0, 7'h31, 8'h00, 1'b0, 32'h0000_0077);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        wait_idle(600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
